// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, branch/trap redirect with flush bubbles,
// stall hold and halt/resume. All outputs are registered.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned BUNDLE_BYTES = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic [31:0] epc,
  output logic        misaligned,
  output logic        halted
);

  // state  | meaning
  // BOOT   | one idle cycle after reset, inputs ignored
  // RUN    | issuing fetches, pc_valid high
  // FLUSH  | squashing wrong-path bundles after a redirect
  // HALTED | fetch stopped until resume or trap
  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'(BUNDLE_BYTES - 1);
  localparam logic [31:0] PC_STEP    = 32'(BUNDLE_BYTES);
  localparam logic [2:0]  CNT_LOAD   = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        misaligned_q, misaligned_d;
  logic        halted_q, halted_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR;
      epc_q        <= 32'h0;
      cnt_q        <= 3'd0;
      pc_valid_q   <= 1'b0;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      cnt_q        <= cnt_d;
      pc_valid_q   <= pc_valid_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
      halted_q     <= halted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    cnt_d        = cnt_q;
    misaligned_d = 1'b0;

    unique case (state_q)
      S_BOOT: state_d = S_RUN;

      S_RUN: begin
        if (trap) begin
          epc_d   = pc_q;
          pc_d    = TRAP_VECTOR;
          cnt_d   = CNT_LOAD;
          state_d = S_FLUSH;
        end else if (branch_taken) begin
          pc_d         = branch_target & ~ALIGN_MASK;
          misaligned_d = (branch_target & ALIGN_MASK) != 32'h0;
          cnt_d        = CNT_LOAD;
          state_d      = S_FLUSH;
        end else if (halt_req) begin
          state_d = S_HALTED;
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end

      // A trap here re-vectors without overwriting the original epc.
      S_FLUSH: begin
        if (trap) begin
          pc_d  = TRAP_VECTOR;
          cnt_d = CNT_LOAD;
        end else if (cnt_q == 3'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_HALTED: begin
        if (trap) begin
          epc_d   = pc_q;
          pc_d    = TRAP_VECTOR;
          cnt_d   = CNT_LOAD;
          state_d = S_FLUSH;
        end else if (resume) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_BOOT;
    endcase

    pc_valid_d = (state_d == S_RUN);
    flush_d    = (state_d == S_FLUSH);
    halted_d   = (state_d == S_HALTED);
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign flush      = flush_q;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;
  localparam logic [31:0] BB = 32'd8;
  localparam int          FC = 2;

  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, trap = 1'b0;
  logic        halt_req = 1'b0, resume = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc, epc;
  logic        pc_valid, flush, misaligned, halted;

  int checks = 0;
  int failures = 0;

  int          m_mode;
  int          m_left;
  logic [31:0] m_pc, m_epc;
  logic        m_mis;

  pc_sequencer #(
    .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .BUNDLE_BYTES(8), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .trap(trap), .halt_req(halt_req), .resume(resume),
    .pc(pc), .pc_valid(pc_valid), .flush(flush), .epc(epc),
    .misaligned(misaligned), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = RV; m_epc = 32'h0; m_left = 0; m_mis = 1'b0;
  endtask

  task automatic model_trap(input logic keep_epc);
    if (!keep_epc) m_epc = m_pc;
    m_pc = TV; m_mode = M_FLUSH; m_left = FC;
  endtask

  // One rising edge of the behavioural model; m_left counts flush cycles still to show.
  task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                            input logic tr, input logic h, input logic r);
    m_mis = 1'b0;
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_RUN: begin
        if (tr) model_trap(1'b0);
        else if (b) begin
          m_pc = t - (t % BB);
          m_mis = (t % BB) != 0;
          m_mode = M_FLUSH; m_left = FC;
        end
        else if (h) m_mode = M_HALT;
        else if (!s) m_pc = m_pc + BB;
      end
      M_FLUSH: begin
        if (tr) model_trap(1'b1);
        else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_RUN;
        end
      end
      default: begin
        if (tr) model_trap(1'b0);
        else if (r) m_mode = M_RUN;
      end
    endcase
  endtask

  task automatic check_all(input string where);
    chk({where, ".pc"}, pc, m_pc);
    chk({where, ".pc_valid"}, 32'(pc_valid), 32'(m_mode == M_RUN));
    chk({where, ".flush"}, 32'(flush), 32'(m_mode == M_FLUSH));
    chk({where, ".halted"}, 32'(halted), 32'(m_mode == M_HALT));
    chk({where, ".epc"}, epc, m_epc);
    chk({where, ".misaligned"}, 32'(misaligned), 32'(m_mis));
  endtask

  // Called just after a falling edge: drive, clock, update model, check at next falling edge.
  task automatic cyc(input string where, input logic s, input logic b, input logic [31:0] t,
                     input logic tr, input logic h, input logic r);
    stall = s; branch_taken = b; branch_target = t; trap = tr; halt_req = h; resume = r;
    @(posedge clk);
    model_step(s, b, t, tr, h, r);
    @(negedge clk);
    check_all(where);
  endtask

  task automatic idle(input string where, input int n);
    for (int i = 0; i < n; i++) cyc(where, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic branch_to(input string where, input logic [31:0] t);
    cyc(where, 0, 1, t, 0, 0, 0);
    idle(where, FC);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;
    #1 check_all("boot");

    // Sequential advance from reset vector
    idle("seq", 3);
    chk("seq.pc_third", pc, 32'h10);
    for (int i = 0; i < 3; i++) cyc("stall", 1, 0, 32'h0, 0, 0, 0);
    chk("stall.hold", pc, 32'h10);
    idle("post_stall", 2);
    chk("post_stall.pc", pc, 32'h20);

    // Misaligned branch under stall
    cyc("br_mis", 1, 1, 32'h104, 0, 0, 0);
    chk("br_mis.pc", pc, 32'h100);
    chk("br_mis.pulse", 32'(misaligned), 32'h1);
    idle("br_flush", FC);
    chk("br_flush.valid", 32'(pc_valid), 32'h1);
    idle("br_resume", 1);
    chk("br_resume.pc", pc, 32'h108);

    // Trap beats branch, then re-vector in first flush cycle
    branch_to("to40", 32'h40);
    cyc("trap_br", 0, 1, 32'h204, 1, 0, 0);
    chk("trap_br.epc", epc, 32'h40);
    chk("trap_br.mis", 32'(misaligned), 32'h0);
    cyc("retrap", 0, 0, 32'h0, 1, 0, 0);
    chk("retrap.epc", epc, 32'h40);
    chk("retrap.flush", 32'(flush), 32'h1);
    idle("retrap_flush", FC);

    // Halt / resume, and trap beating resume
    branch_to("to30", 32'h30);
    cyc("halt", 0, 0, 32'h0, 0, 1, 0);
    idle("halted", 5);
    chk("halted.pc", pc, 32'h30);
    cyc("resume", 0, 0, 32'h0, 0, 0, 1);
    chk("resume.valid", 32'(pc_valid), 32'h1);
    idle("resume_adv", 1);
    chk("resume_adv.pc", pc, 32'h38);
    cyc("halt2", 0, 0, 32'h0, 0, 1, 0);
    cyc("halt_trap", 0, 0, 32'h0, 1, 0, 1);
    chk("halt_trap.pc", pc, TV);
    idle("halt_trap_flush", FC);

    // Wrap at top of address space
    branch_to("to_top", 32'hFFFF_FFF8);
    idle("wrap", 1);
    chk("wrap.pc", pc, 32'h0);

    // Asynchronous reset in the middle of a flush
    cyc("pre_rst", 0, 1, 32'h500, 0, 0, 0);
    @(posedge clk);
    model_step(0, 0, 32'h0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    #1 check_all("boot2");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t = t & ~(BB - 1);
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
      cyc("rand",
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          t,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
